// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side packet reader.
package async_fifo_pkg;

  localparam int LEN_WIDTH          = 8;
  localparam int PKT_COUNT_WIDTH    = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    ST_HDR,
    ST_PAYLOAD
  } rd_state_e;

  // Output-buffer entry at the default data width; wider builds supply their own entry type.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          last;
  } buf_entry_t;

endpackage

// File: rtl/async_fifo_skid_buffer.sv
// Two-entry output buffer of {data, last}: head register drives the stream, tail absorbs backpressure.
module async_fifo_skid_buffer
  import async_fifo_pkg::*;
#(
  parameter type entry_t = buf_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] occ
);

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic [1:0] land_idx;
  logic       do_push;
  logic       do_pop;

  assign do_pop   = pop && (occ_q != 2'd0);
  assign do_push  = push && ((occ_q != 2'd2) || do_pop);
  assign land_idx = occ_q - 2'(do_pop);

  always_comb begin
    // NOTE: every variable gets a default first so no branch leaves it unassigned and infers a latch.
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q + 2'(do_push) - 2'(do_pop);
    if (do_pop) begin
      head_d = tail_q;
    end
    if (do_push) begin
      if (land_idx == 2'd0) begin
        head_d = push_entry;
      end else begin
        tail_d = push_entry;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage is reset too (only two entries) so the stream data reads 0 out of reset.
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head = head_q;
  assign occ  = occ_q;

endmodule

// File: rtl/async_fifo_packet_reader.sv
// Read-side packet reader: pops length-prefixed packets from the async FIFO and streams the payload.
// Define ASYNC_FIFO_PKT_STATS_EN to add the 16-bit pkt_count completed-packet counter.
module async_fifo_packet_reader
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy
`ifdef ASYNC_FIFO_PKT_STATS_EN
  ,
  output logic [PKT_COUNT_WIDTH-1:0] pkt_count
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  rd_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 inflight_q;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [1:0]           occ;
  logic [2:0]           credit_use;
  logic                 pop;
  logic                 push;
  entry_t               push_entry;
  entry_t               head_entry;

  assign hdr_len = read_data[LEN_WIDTH-1:0];
  assign pop     = m_valid && m_ready;

  // Every issued read holds a slot until it lands; a header frees its slot on arrival.
  assign credit_use = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign read_en    = !empty && !reset && (credit_use < 3'(BUF_DEPTH));

  // The FSM advances on data arrival (the cycle after read_en), never on the request.
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    push            = 1'b0;
    push_entry.data = read_data;
    push_entry.last = 1'b0;
    if (inflight_q) begin
      unique case (state_q)
        ST_HDR: begin
          len_d = hdr_len;
          if (hdr_len != '0) begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          push            = 1'b1;
          push_entry.last = (len_q == LEN_WIDTH'(1));
          len_d           = len_q - LEN_WIDTH'(1);
          if (len_q == LEN_WIDTH'(1)) begin
            state_d = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q    <= ST_HDR;
      len_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      inflight_q <= read_en;
    end
  end

  async_fifo_skid_buffer #(
    .entry_t(entry_t)
  ) u_out_buf (
    .clk        (rd_clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head_entry),
    .occ        (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_entry.data;
  assign m_last  = head_entry.last;
  assign busy    = (state_q == ST_PAYLOAD);

`ifdef ASYNC_FIFO_PKT_STATS_EN
  logic                       zero_hdr;
  logic [1:0]                 pkt_inc;
  logic [PKT_COUNT_WIDTH-1:0] pkt_count_q;

  // A last-beat pop and a zero-length header can complete two packets in one cycle.
  assign zero_hdr = inflight_q && (state_q == ST_HDR) && (hdr_len == '0);
  assign pkt_inc  = {1'b0, pop && m_last} + {1'b0, zero_hdr};

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_q + PKT_COUNT_WIDTH'(pkt_inc);
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_async_fifo_packet_reader.sv
// Bench for async_fifo_packet_reader: queue-based FIFO and packet model, directed timing plus random traffic.
module tb_async_fifo_packet_reader;

  localparam int DW = 8;

  logic          rd_clk = 1'b0;
  logic          reset = 1'b1;
  logic          empty = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic          read_en, m_valid, m_last, busy;
  logic [DW-1:0] m_data;
`ifdef ASYNC_FIFO_PKT_STATS_EN
  logic [15:0]   pkt_count;
`endif

  always #5 rd_clk = ~rd_clk;

  async_fifo_packet_reader #(
    .DATA_WIDTH(DW),
    .BUF_DEPTH (2)
  ) dut (
    .rd_clk   (rd_clk),
    .reset    (reset),
    .empty    (empty),
    .read_data(read_data),
    .read_en  (read_en),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .busy     (busy)
`ifdef ASYNC_FIFO_PKT_STATS_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  typedef struct {
    logic [7:0] data;
    bit         hdr;
  } fent_t;

  fent_t      fifo[$];
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  int         exp_pkts = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  bit rst_req = 1'b1;
  bit toggle_empty = 1'b0;
  int gap_pct = 0;
  int ready_pct = 100;
  int rlo = -1;
  int rhi = -1;
  int cyc = 0;

  logic [7:0] pend;
  bit         pend_v = 1'b0;
  int         reads_total = 0, acc_total = 0, hdr_le_tm2 = 0;
  bit         f1 = 1'b0, f2 = 1'b0;
  int         qmax, bad_rd_empty, extra, beats, first_beat_cyc, last_beat_cyc;
  bit         hold_v = 1'b0;
  logic [7:0] hold_data;
  bit         hold_last;

  bit         rd_log[64], mv_log[64], last_log[64], busy_log[64];
  logic [7:0] data_log[64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Packet model: header L, then L payload bytes; the last byte of each packet carries m_last.
  task automatic add_pkt(input int len, input logic [7:0] base, input bit rnd);
    fent_t      e;
    logic [7:0] b;
    e.data = 8'(len);
    e.hdr  = 1'b1;
    fifo.push_back(e);
    for (int i = 0; i < len; i++) begin
      b      = rnd ? 8'($urandom) : base + 8'(i);
      e.data = b;
      e.hdr  = 1'b0;
      fifo.push_back(e);
      exp_data.push_back(b);
      exp_last.push_back(i == len - 1);
    end
    exp_pkts++;
  endtask

  task automatic cycle();
    fent_t e;
    int    q;
    @(posedge rd_clk);
    #1;
    reset     = rst_req;
    read_data = pend_v ? pend : 8'($urandom);
    pend_v    = 1'b0;
    empty     = (fifo.size() == 0) ||
                (toggle_empty ? (cyc % 2 == 1) : ($urandom_range(99) < gap_pct));
    m_ready   = ((cyc >= rlo) && (cyc <= rhi)) ? 1'b0 : ($urandom_range(99) < ready_pct);
    @(negedge rd_clk);
    if (cyc < 64) begin
      rd_log[cyc]   = read_en;
      mv_log[cyc]   = m_valid;
      last_log[cyc] = m_last;
      busy_log[cyc] = busy;
      data_log[cyc] = m_data;
    end
    if (reset) begin
      reads_total = 0;
      acc_total   = 0;
      hdr_le_tm2  = 0;
      f1          = 1'b0;
      f2          = 1'b0;
      hold_v      = 1'b0;
    end else begin
      if (read_en && empty) bad_rd_empty++;
      hdr_le_tm2 += int'(f2);
      f2 = f1;
      f1 = 1'b0;
      if (read_en && fifo.size() != 0) begin
        e           = fifo.pop_front();
        pend        = e.data;
        pend_v      = 1'b1;
        f1          = e.hdr;
        reads_total++;
      end
      if (hold_v) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_data);
        check("hold_last", m_last, hold_last);
      end
      if (m_valid && m_ready) begin
        acc_total++;
        beats++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        if (exp_data.size() == 0) begin
          extra++;
        end else begin
          check("beat_data", m_data, exp_data.pop_front());
          check("beat_last", m_last, exp_last.pop_front());
        end
      end
      hold_v    = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
      // Fetched-but-undelivered entries; a header stops counting once it has arrived.
      q = reads_total - hdr_le_tm2 - acc_total;
      if (q > qmax) qmax = q;
    end
    cyc++;
  endtask

  task automatic begin_scen();
    cyc            = 0;
    beats          = 0;
    qmax           = 0;
    bad_rd_empty   = 0;
    extra          = 0;
    first_beat_cyc = -1;
    last_beat_cyc  = -1;
    rlo            = -1;
    rhi            = -1;
    foreach (rd_log[i]) begin
      rd_log[i]   = 1'b0;
      mv_log[i]   = 1'b0;
      last_log[i] = 1'b0;
      busy_log[i] = 1'b0;
      data_log[i] = '0;
    end
  endtask

  task automatic drain(input string s, input int budget);
    int n;
    n = 0;
    while ((exp_data.size() != 0 || fifo.size() != 0 || pend_v || m_valid) && n < budget) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    check({s, "_drain_in_budget"}, n < budget, 1);
  endtask

  task automatic end_scen(input string s);
    check({s, "_rd_en_while_empty"}, bad_rd_empty, 0);
    check({s, "_credit_max_le2"}, qmax <= 2, 1);
    check({s, "_extra_beats"}, extra, 0);
    check({s, "_missing_beats"}, exp_data.size(), 0);
`ifdef ASYNC_FIFO_PKT_STATS_EN
    check({s, "_pkt_count"}, pkt_count, 16'(exp_pkts));
`endif
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    fifo.delete();
    exp_data.delete();
    exp_last.delete();
    exp_pkts = 0;
    repeat (2) cycle();
    rst_req = 1'b0;
    cycle();
  endtask

  initial begin
    int n_rd;

    // Reset state
    begin_scen();
    rst_req = 1'b1;
    repeat (3) cycle();
    check("rst_read_en", read_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
`ifdef ASYNC_FIFO_PKT_STATS_EN
    check("rst_pkt_count", pkt_count, 0);
`endif
    rst_req = 1'b0;
    repeat (2) cycle();

    // 03,A1,A2,A3 with m_ready high: latency, m_last and busy timing
    begin_scen();
    add_pkt(3, 8'hA1, 1'b0);
    repeat (8) cycle();
    check("s1_rd_en_c0", rd_log[0], 1);
    check("s1_rd_en_c1", rd_log[1], 1);
    check("s1_valid_c2", mv_log[2], 0);
    check("s1_valid_c3", mv_log[3], 1);
    check("s1_data_c3", data_log[3], 8'hA1);
    check("s1_data_c4", data_log[4], 8'hA2);
    check("s1_data_c5", data_log[5], 8'hA3);
    check("s1_last_c3", last_log[3], 0);
    check("s1_last_c4", last_log[4], 0);
    check("s1_last_c5", last_log[5], 1);
    check("s1_valid_c6", mv_log[6], 0);
    check("s1_busy_c1", busy_log[1], 0);
    check("s1_busy_c2", busy_log[2], 1);
    check("s1_busy_c4", busy_log[4], 1);
    check("s1_busy_c5", busy_log[5], 0);
    drain("s1", 200);
    end_scen("s1");

    // Zero-length packet then 01,B7
    do_reset();
    begin_scen();
    add_pkt(0, 8'h00, 1'b0);
    add_pkt(1, 8'hB7, 1'b0);
    drain("s2", 200);
    check("s2_beats", beats, 1);
    end_scen("s2");

    // Length 6 with m_ready low for cycles 3..9
    begin_scen();
    add_pkt(6, 8'h31, 1'b0);
    rlo = 3;
    rhi = 9;
    repeat (11) cycle();
    n_rd = 0;
    for (int i = 1; i <= 9; i++) n_rd += int'(rd_log[i]);
    check("s3_reads_during_stall", n_rd, 2);
    check("s3_valid_c9", mv_log[9], 1);
    check("s3_data_c9", data_log[9], 8'h31);
    drain("s3", 200);
    check("s3_beats", beats, 6);
    end_scen("s3");

    // Back-to-back 02,C1,C2,02,D1,D2
    begin_scen();
    add_pkt(2, 8'hC1, 1'b0);
    add_pkt(2, 8'hD1, 1'b0);
    drain("s4", 200);
    check("s4_first_beat_cyc", first_beat_cyc, 3);
    check("s4_last_beat_cyc", last_beat_cyc, 7);
    check("s4_bubble_c5", mv_log[5], 0);
    check("s4_beats", beats, 4);
    end_scen("s4");

    // Reset the cycle after C1 is accepted, mid-packet, then a fresh 01,E5
    begin_scen();
    add_pkt(4, 8'hC1, 1'b0);
    repeat (4) cycle();
    check("s5_c1_accepted", beats, 1);
    rst_req = 1'b1;
    fifo.delete();
    exp_data.delete();
    exp_last.delete();
    exp_pkts = 0;
    cycle();
    rst_req = 1'b0;
    cycle();
    check("s5_rd_en_in_reset", rd_log[4], 0);
    check("s5_busy_before", busy_log[4], 1);
    check("s5_valid_after", mv_log[5], 0);
    check("s5_rd_en_after", rd_log[5], 0);
    check("s5_busy_after", busy_log[5], 0);
    beats = 0;
    add_pkt(1, 8'hE5, 1'b0);
    drain("s5", 200);
    check("s5_beats", beats, 1);
    end_scen("s5");

    // empty toggling every cycle mid-packet
    begin_scen();
    toggle_empty = 1'b1;
    add_pkt(8, 8'h60, 1'b0);
    drain("s6", 400);
    toggle_empty = 1'b0;
    check("s6_beats", beats, 8);
    end_scen("s6");

    // Random traffic: random lengths incl. 0 and 255, random gaps and backpressure
    begin_scen();
    gap_pct   = 30;
    ready_pct = 60;
    for (int p = 0; p < 24; p++) begin
      if (p == 12) add_pkt(255, 8'h00, 1'b1);
      else add_pkt(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)), 8'h00, 1'b1);
    end
    drain("s7", 20000);
    end_scen("s7");
    gap_pct   = 0;
    ready_pct = 100;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
